// File: rtl/usb3_ep_hs_arb_pkg.sv
// usb3_ep_hs_arb_pkg
// Shared definitions for the endpoint handshake arbiter:
//   - state_t    : sequencer states (IDLE, DRIVE, RELEASE, GAP)
//   - req_type_t : request type, buffer commit (RX) or buffer arm (TX)
//   - EP_IDX_W   : endpoint index width (fixed, up to four endpoints)
//   - ep_onehot  : endpoint index to one-hot strobe vector
package usb3_ep_hs_arb_pkg;

  localparam int unsigned EP_IDX_W = 2;
  localparam int unsigned EP_MAX   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE,
    GAP
  } state_t;

  typedef enum logic {
    REQ_COMMIT = 1'b0,
    REQ_ARM    = 1'b1
  } req_type_t;

  typedef logic [EP_IDX_W-1:0] ep_idx_t;

  function automatic logic [EP_MAX-1:0] ep_onehot(input ep_idx_t ep);
    logic [EP_MAX-1:0] oh;
    oh     = '0;
    oh[ep] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/usb3_rr_arb2.sv
// usb3_rr_arb2
// Two-requester round-robin picker with registered last-served state.
// Ports:
//   local_clk  clock
//   reset_n    synchronous active-low reset (last-served resets to requester 1)
//   pick_en    grant is only produced (and history updated) while high
//   req[1:0]   request levels, bit 0 = requester 0, bit 1 = requester 1
//   gnt[1:0]   combinational one-hot grant, zero when pick_en is low
module usb3_rr_arb2 (
  input  logic       local_clk,
  input  logic       reset_n,
  input  logic       pick_en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when requester 1 was the most recent winner.
  logic last_1;

  always_comb begin
    gnt = 2'b00;
    if (pick_en) begin
      if (req == 2'b11) begin
        gnt = last_1 ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      last_1 <= 1'b1;
    end else if (pick_en && (req != 2'b00)) begin
      last_1 <= gnt[1];
    end
  end

endmodule

// File: rtl/usb3_ep_hs_arb.sv
// usb3_ep_hs_arb
// Serializes RX buffer-commit and TX buffer-arm requests onto the endpoint
// strobes, waits for each endpoint's level ack to rise and fall, enforces a
// strobe-low gap between transactions and returns one done per request.
//
// Parameters: NUM_EP (attached endpoints, 1..4), TIMEOUT (cycles per ack
// phase before abort), GAP_CYC (strobe-low cycles between transactions).
//
// Ports:
//   local_clk, reset_n           clock, synchronous active-low reset
//   rx_req/rx_ep/rx_len          RX commit request (held until rx_gnt)
//   rx_gnt, rx_done              RX grant and completion pulses
//   tx_req/tx_ep                 TX arm request (held until tx_gnt)
//   tx_gnt, tx_done              TX grant and completion pulses
//   ep_commit, ep_commit_len     per-endpoint commit strobe, latched length
//   ep_commit_ack                per-endpoint commit ack (level)
//   ep_arm, ep_arm_ack           per-endpoint arm strobe and ack (level)
//   err_timeout, err_badep       error pulses
//   err_ep                       endpoint index of the last error
//
// Build option: define USB3_EP_HS_ARB_TIMEOUT_EN to enable the per-phase ack
// timeout; without it the sequencer waits indefinitely and err_timeout is 0.
import usb3_ep_hs_arb_pkg::*;

module usb3_ep_hs_arb #(
  parameter int unsigned NUM_EP  = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        rx_req,
  input  logic [1:0]  rx_ep,
  input  logic [10:0] rx_len,
  output logic        rx_gnt,
  output logic        rx_done,
  input  logic        tx_req,
  input  logic [1:0]  tx_ep,
  output logic        tx_gnt,
  output logic        tx_done,
  output logic [3:0]  ep_commit,
  output logic [10:0] ep_commit_len,
  input  logic [3:0]  ep_commit_ack,
  output logic [3:0]  ep_arm,
  input  logic [3:0]  ep_arm_ack,
  output logic        err_timeout,
  output logic        err_badep,
  output logic [1:0]  err_ep
);

  localparam logic [2:0] NUM_EP_V = 3'(NUM_EP);
  // A zero gap is treated as a single strobe-low cycle.
  localparam logic [7:0] GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_t    state;
  req_type_t cur_type;
  ep_idx_t   cur_ep;
  logic [7:0] gap_cnt;

  logic [1:0] arb_gnt;
  logic       pick_en;
  ep_idx_t    sel_ep;
  logic       sel_bad;
  logic       ack_level;

`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] phase_cnt;
`else
  // TIMEOUT has no effect in this build; the sequencer never aborts.
  assign err_timeout = (TIMEOUT == 0) & 1'b0;
`endif

  assign pick_en = (state == IDLE);

  usb3_rr_arb2 u_rr_arb2 (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .pick_en   (pick_en),
    .req       ({tx_req, rx_req}),
    .gnt       (arb_gnt)
  );

  always_comb begin
    sel_ep  = arb_gnt[0] ? rx_ep : tx_ep;
    sel_bad = ({1'b0, sel_ep} >= NUM_EP_V);
  end

  // Ack is taken by level, so an ack already high on entry to DRIVE counts.
  always_comb begin
    ack_level = 1'b0;
    if (cur_type == REQ_COMMIT) begin
      ack_level = ep_commit_ack[cur_ep];
    end else begin
      ack_level = ep_arm_ack[cur_ep];
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cur_type      <= REQ_COMMIT;
      cur_ep        <= '0;
      gap_cnt       <= '0;
      ep_commit     <= '0;
      ep_arm        <= '0;
      ep_commit_len <= '0;
      rx_gnt        <= 1'b0;
      tx_gnt        <= 1'b0;
      rx_done       <= 1'b0;
      tx_done       <= 1'b0;
      err_badep     <= 1'b0;
      err_ep        <= '0;
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
      err_timeout   <= 1'b0;
      phase_cnt     <= '0;
`endif
    end else begin
      rx_gnt    <= 1'b0;
      tx_gnt    <= 1'b0;
      rx_done   <= 1'b0;
      tx_done   <= 1'b0;
      err_badep <= 1'b0;
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            rx_gnt   <= arb_gnt[0];
            tx_gnt   <= arb_gnt[1];
            cur_ep   <= sel_ep;
            cur_type <= arb_gnt[0] ? REQ_COMMIT : REQ_ARM;
            if (arb_gnt[0]) begin
              ep_commit_len <= rx_len;
            end
            if (sel_bad) begin
              // Unattached endpoint: no strobe and no done, just the gap.
              err_badep <= 1'b1;
              err_ep    <= sel_ep;
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              if (arb_gnt[0]) begin
                ep_commit <= ep_onehot(sel_ep);
              end else begin
                ep_arm <= ep_onehot(sel_ep);
              end
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
              phase_cnt <= '0;
`endif
              state <= DRIVE;
            end
          end
        end

        DRIVE: begin
          if (ack_level) begin
            ep_commit <= '0;
            ep_arm    <= '0;
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
            phase_cnt <= '0;
`endif
            state <= RELEASE;
          end
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
          else if (phase_cnt == TO_LAST) begin
            ep_commit   <= '0;
            ep_arm      <= '0;
            err_timeout <= 1'b1;
            err_ep      <= cur_ep;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
`endif
        end

        RELEASE: begin
          if (!ack_level) begin
            if (cur_type == REQ_COMMIT) begin
              rx_done <= 1'b1;
            end else begin
              tx_done <= 1'b1;
            end
            gap_cnt <= '0;
            state   <= GAP;
          end
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
          else if (phase_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            err_ep      <= cur_ep;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
`endif
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_ep_hs_arb.sv
// tb_usb3_ep_hs_arb
// Scoreboard bench for usb3_ep_hs_arb. Stimulus pushes the expected pulse
// events (kind, endpoint, cycle) into a queue; a negedge monitor pops and
// compares whenever the DUT raises a gnt/done/error pulse. Endpoints are
// modelled as a 2-FF synchronizer plus an ack register on each strobe bit.
// The DUT is built with NUM_EP=3 so that index 3 is an unattached endpoint.
module tb_usb3_ep_hs_arb;

  localparam int unsigned NUM_EP  = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned GAP_CYC = 2;

  logic        local_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic        rx_req    = 1'b0;
  logic [1:0]  rx_ep     = '0;
  logic [10:0] rx_len    = '0;
  logic        tx_req    = 1'b0;
  logic [1:0]  tx_ep     = '0;
  logic        rx_gnt, rx_done, tx_gnt, tx_done;
  logic [3:0]  ep_commit, ep_arm;
  logic [10:0] ep_commit_len;
  logic [3:0]  ep_commit_ack = '0;
  logic [3:0]  ep_arm_ack    = '0;
  logic        err_timeout, err_badep;
  logic [1:0]  err_ep;

  logic [3:0] c1 = '0, c2 = '0, a1 = '0, a2 = '0;
  logic [3:0] kill_mask = '0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int overlap_cnt = 0;
  int arm_hi = 0;

  typedef enum int {EV_GNT_RX, EV_GNT_TX, EV_BADEP, EV_TIMEOUT, EV_DONE_RX, EV_DONE_TX} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       ep;
    int       cyc;
  } ev_t;
  ev_t exp_q[$];

  usb3_ep_hs_arb #(
    .NUM_EP  (NUM_EP),
    .TIMEOUT (TIMEOUT),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .local_clk     (local_clk),
    .reset_n       (reset_n),
    .rx_req        (rx_req),
    .rx_ep         (rx_ep),
    .rx_len        (rx_len),
    .rx_gnt        (rx_gnt),
    .rx_done       (rx_done),
    .tx_req        (tx_req),
    .tx_ep         (tx_ep),
    .tx_gnt        (tx_gnt),
    .tx_done       (tx_done),
    .ep_commit     (ep_commit),
    .ep_commit_len (ep_commit_len),
    .ep_commit_ack (ep_commit_ack),
    .ep_arm        (ep_arm),
    .ep_arm_ack    (ep_arm_ack),
    .err_timeout   (err_timeout),
    .err_badep     (err_badep),
    .err_ep        (err_ep)
  );

  always #5 local_clk = ~local_clk;

  always @(posedge local_clk) cyc <= cyc + 1;

  // Endpoint model: ack follows the strobe through two sync stages and an
  // ack register; kill_mask suppresses commit acks.
  always @(posedge local_clk) begin
    c1            <= ep_commit;
    c2            <= c1;
    ep_commit_ack <= c2 & ~kill_mask;
    a1            <= ep_arm;
    a2            <= a1;
    ep_arm_ack    <= a2;
  end

  task automatic tick;
    @(posedge local_clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int ep, input int c);
    ev_t e;
    e.kind = k;
    e.ep   = ep;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int ep);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %s ep=%0d at cycle %0d, expected none", k.name(), ep, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc ||
          ((k == EV_BADEP || k == EV_TIMEOUT) && e.ep != ep)) begin
        fails++;
        $display("FAIL event: got %s ep=%0d cycle=%0d, expected %s ep=%0d cycle=%0d",
                 k.name(), ep, cyc, e.kind.name(), e.ep, e.cyc);
      end
    end
  endtask

  always @(negedge local_clk) begin
    if ($countones({ep_commit, ep_arm}) > 1) overlap_cnt++;
    if (ep_arm != '0) arm_hi++;
    if (rx_gnt)      observe(EV_GNT_RX, 0);
    if (tx_gnt)      observe(EV_GNT_TX, 0);
    if (err_badep)   observe(EV_BADEP, int'(err_ep));
    if (err_timeout) observe(EV_TIMEOUT, int'(err_ep));
    if (rx_done)     observe(EV_DONE_RX, 0);
    if (tx_done)     observe(EV_DONE_TX, 0);
  end

  task automatic wait_gnt(input bit is_rx, input string name);
    int i;
    i = 0;
    tick;
    while (!(is_rx ? rx_gnt : tx_gnt) && i < 40) begin
      tick;
      i++;
    end
    check(name, int'(is_rx ? rx_gnt : tx_gnt), 1);
  endtask

  // Plain RX commit against the endpoint model; FSM must be IDLE on entry.
  task automatic run_rx(input int ep, input int len);
    int n;
    n = cyc;
    expect_ev(EV_GNT_RX, 0, n + 1);
    expect_ev(EV_DONE_RX, 0, n + 9);
    rx_ep  = 2'(ep);
    rx_len = 11'(len);
    rx_req = 1'b1;
    tick;
    rx_req = 1'b0;
    check("rx_len_latched", int'(ep_commit_len), len);
    check("rx_strobe", int'(ep_commit), 1 << ep);
    repeat (11) tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int a0;

    // Reset values
    tick;
    tick;
    check("rst_commit", int'(ep_commit), 0);
    check("rst_arm", int'(ep_arm), 0);
    check("rst_len", int'(ep_commit_len), 0);
    check("rst_err_ep", int'(err_ep), 0);
    check("rst_pulses", int'({rx_gnt, tx_gnt, rx_done, tx_done, err_badep, err_timeout}), 0);
    reset_n = 1'b1;
    tick;

    // RX only to EP0, length 64
    n  = cyc;
    a0 = arm_hi;
    expect_ev(EV_GNT_RX, 0, n + 1);
    expect_ev(EV_DONE_RX, 0, n + 9);
    rx_ep  = 2'd0;
    rx_len = 11'd64;
    rx_req = 1'b1;
    wait_gnt(1'b1, "t1_rx_gnt");
    rx_req = 1'b0;
    check("t1_commit_on", int'(ep_commit), 1);
    check("t1_len", int'(ep_commit_len), 64);
    repeat (3) tick;
    check("t1_commit_until_ack", int'(ep_commit), 1);
    tick;
    check("t1_commit_drop", int'(ep_commit), 0);
    repeat (7) tick;
    check("t1_no_arm", arm_hi, a0);

    // Simultaneous requests after reset: RX wins, TX waits out the gap
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    n = cyc;
    expect_ev(EV_GNT_RX, 0, n + 1);
    expect_ev(EV_DONE_RX, 0, n + 9);
    expect_ev(EV_GNT_TX, 0, n + 12);
    expect_ev(EV_DONE_TX, 0, n + 20);
    rx_ep  = 2'd1;
    rx_len = 11'd100;
    tx_ep  = 2'd2;
    rx_req = 1'b1;
    tx_req = 1'b1;
    wait_gnt(1'b1, "t2_rx_gnt");
    rx_req = 1'b0;
    check("t2_commit_ep1", int'(ep_commit), 2);
    check("t2_no_arm_yet", int'(ep_arm), 0);
    wait_gnt(1'b0, "t2_tx_gnt");
    tx_req = 1'b0;
    check("t2_tx_gnt_cycle", cyc, n + 12);
    check("t2_arm_ep2", int'(ep_arm), 4);
    check("t2_commit_idle", int'(ep_commit), 0);
    repeat (10) tick;

    // Both held continuously: RX, TX, RX, TX; length changes only on RX grant
    n = cyc;
    expect_ev(EV_GNT_RX, 0, n + 1);
    expect_ev(EV_DONE_RX, 0, n + 9);
    expect_ev(EV_GNT_TX, 0, n + 12);
    expect_ev(EV_DONE_TX, 0, n + 20);
    expect_ev(EV_GNT_RX, 0, n + 23);
    expect_ev(EV_DONE_RX, 0, n + 31);
    expect_ev(EV_GNT_TX, 0, n + 34);
    expect_ev(EV_DONE_TX, 0, n + 42);
    rx_ep  = 2'd2;
    rx_len = 11'd7;
    tx_ep  = 2'd0;
    rx_req = 1'b1;
    tx_req = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick;
      if (i == 1)  check("t3_commit_ep2", int'(ep_commit), 4);
      if (i == 2)  rx_len = 11'd9;
      if (i == 12) check("t3_arm_ep0", int'(ep_arm), 1);
      if (i == 14) check("t3_len_held", int'(ep_commit_len), 7);
      if (i == 24) check("t3_len_new", int'(ep_commit_len), 9);
    end
    rx_req = 1'b0;
    tx_req = 1'b0;
    repeat (12) tick;

    // TX to unattached endpoint 3
    n  = cyc;
    a0 = arm_hi;
    expect_ev(EV_GNT_TX, 0, n + 1);
    expect_ev(EV_BADEP, 3, n + 1);
    tx_ep  = 2'd3;
    tx_req = 1'b1;
    tick;
    tx_req = 1'b0;
    check("t4_err_ep", int'(err_ep), 3);
    tick;
    tick;
    check("t4_err_ep_hold", int'(err_ep), 3);
    check("t4_no_arm", arm_hi, a0);
    run_rx(1, 12);

    // Commit ack withheld
    kill_mask = 4'b1111;
    n = cyc;
    expect_ev(EV_GNT_RX, 0, n + 1);
    rx_ep  = 2'd1;
    rx_len = 11'd33;
    rx_req = 1'b1;
`ifdef USB3_EP_HS_ARB_TIMEOUT_EN
    expect_ev(EV_TIMEOUT, 1, n + 17);
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (i == 1)  rx_req = 1'b0;
      if (i == 16) check("t5_strobe_last", int'(ep_commit), 2);
      if (i == 17) check("t5_strobe_drop", int'(ep_commit), 0);
      if (i == 17) check("t5_err_ep", int'(err_ep), 1);
    end
    kill_mask = '0;
`else
    expect_ev(EV_DONE_RX, 0, n + 47);
    for (int i = 1; i <= 41; i++) begin
      tick;
      if (i == 1)  rx_req = 1'b0;
      if (i == 41) check("t5_strobe_held", int'(ep_commit), 2);
    end
    kill_mask = '0;
    repeat (9) tick;
    check("t5_err_ep_kept", int'(err_ep), 3);
`endif
    run_rx(0, 5);

    // Reset during RELEASE discards the pending done
    n = cyc;
    expect_ev(EV_GNT_RX, 0, n + 1);
    rx_ep  = 2'd2;
    rx_len = 11'd20;
    rx_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (i == 1) rx_req = 1'b0;
      if (i == 5) check("t6_in_release", int'(ep_commit), 0);
    end
    reset_n = 1'b0;
    tick;
    check("t6_rst_commit", int'(ep_commit), 0);
    check("t6_rst_arm", int'(ep_arm), 0);
    check("t6_rst_len", int'(ep_commit_len), 0);
    tick;
    reset_n = 1'b1;
    repeat (4) tick;
    run_rx(0, 64);

    repeat (3) tick;
    check("queue_empty", exp_q.size(), 0);
    check("strobe_overlap", overlap_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
